// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and default parameters for the fetch stage.
package fetch_pkg;
    typedef enum logic [1:0] {F_IDLE, F_REQ, F_DRAIN} fetch_state_t;
    localparam logic [31:0] RESET_PC_DEF      = 32'h0000_0000;
    localparam int          FETCH_TIMEOUT_DEF = 255;
endpackage

// File: rtl/fetch_watchdog.sv
// fetch_watchdog: saturating wait counter; expire fires on the last allowed non-ack cycle.
module fetch_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rstn,
    input  logic run,
    input  logic clear,
    output logic expire
);
    localparam int W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clear ? '0 : (run && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
    assign expire = (TIMEOUT > 0) && run && cnt_q == LAST;
endmodule

// File: rtl/fetch.sv
// fetch: req/ack instruction fetch stage with flush, pending reissue and watchdog fault.
// Optional FETCH_MISALIGN_CHECK_EN reports misaligned pc_in instead of fetching.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = RESET_PC_DEF,
    parameter int          FETCH_TIMEOUT = FETCH_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enabled,
    input  logic [31:0] pc_in,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        completed,
    output logic [31:0] instr_raw,
    output logic [31:0] pc,
    output logic        misaligned,
    output logic        fault
);
    fetch_state_t state_q, state_d;
    logic        mem_req_q, mem_req_d, done_q, done_d, mis_q, mis_d;
    logic        fault_q, fault_d, pend_q, pend_d;
    logic [31:0] addr_q, addr_d, pc_q, pc_d, instr_q, instr_d, pend_pc_q, pend_pc_d;
    logic [31:0] start_pc;
    logic        go, run, clear, expire;

    // A pending flush+enabled request takes precedence over a fresh pulse.
    assign start_pc = pend_q ? pend_pc_q : pc_in;
    assign go       = pend_q || (enabled && !fault_q);
    assign run      = state_q != F_IDLE && !mem_ack;
    assign clear    = state_d != F_IDLE && state_d != state_q;

    fetch_watchdog #(.TIMEOUT(FETCH_TIMEOUT)) u_wdog (
        .clk    (clk),
        .rstn   (rstn),
        .run    (run),
        .clear  (clear),
        .expire (expire)
    );

    always_comb begin
        state_d   = state_q;
        mem_req_d = mem_req_q;
        addr_d    = addr_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        done_d    = done_q;
        mis_d     = mis_q;
        fault_d   = fault_q;
        pend_d    = pend_q;
        pend_pc_d = pend_pc_q;
        case (state_q)
            F_IDLE: begin
                if (flush) done_d = 1'b0;
                if (go) begin
                    pc_d   = start_pc;
                    addr_d = {start_pc[31:2], 2'b00};
                    done_d = 1'b0;
                    mis_d  = 1'b0;
                    pend_d = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
                    if (start_pc[1:0] != 2'b00) begin
                        instr_d = '0;
                        mis_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        mem_req_d = 1'b1;
                        state_d   = F_REQ;
                    end
`else
                    mem_req_d = 1'b1;
                    state_d   = F_REQ;
`endif
                end
            end
            default: begin
                if (flush) begin
                    pend_d    = enabled;
                    pend_pc_d = pc_in;
                end
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = F_IDLE;
                    if (state_q == F_REQ && !flush) begin
                        instr_d = mem_rdata;
                        done_d  = 1'b1;
                    end
                end else if (expire) begin
                    fault_d   = 1'b1;
                    mem_req_d = 1'b0;
                    pend_d    = 1'b0;
                    done_d    = 1'b0;
                    state_d   = F_IDLE;
                end else if (flush) begin
                    state_d = F_DRAIN;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= F_IDLE;
            mem_req_q <= 1'b0;
            addr_q    <= RESET_PC;
            pc_q      <= RESET_PC;
            instr_q   <= '0;
            done_q    <= 1'b0;
            mis_q     <= 1'b0;
            fault_q   <= 1'b0;
            pend_q    <= 1'b0;
            pend_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            mem_req_q <= mem_req_d;
            addr_q    <= addr_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            done_q    <= done_d;
            mis_q     <= mis_d;
            fault_q   <= fault_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_addr   = addr_q;
    assign pc         = pc_q;
    assign instr_raw  = instr_q;
    assign misaligned = mis_q;
    assign fault      = fault_q;
    assign completed  = done_q && !enabled;
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed stimulus with a completion scoreboard for the fetch stage.
module tb_fetch;
    localparam logic [31:0] RPC = 32'h0000_1000;

    logic        clk = 1'b0, rstn = 1'b0;
    logic        enabled = 1'b0, flush = 1'b0, mem_ack = 1'b0;
    logic [31:0] pc_in = '0, mem_rdata = '0;
    logic        mem_req, completed, misaligned, fault;
    logic [31:0] mem_addr, instr_raw, pc;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        mis;
    } exp_t;
    exp_t q[$];
    int   checks = 0, errors = 0;
    logic comp_prev = 1'b0;

    fetch #(.RESET_PC(RPC), .FETCH_TIMEOUT(8)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .enabled    (enabled),
        .pc_in      (pc_in),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .completed  (completed),
        .instr_raw  (instr_raw),
        .pc         (pc),
        .misaligned (misaligned),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_done(input logic [31:0] instr, input logic [31:0] p, input logic mis);
        exp_t e;
        e.instr = instr;
        e.pc    = p;
        e.mis   = mis;
        q.push_back(e);
    endtask

    // Completion monitor: every rising edge of completed must match the oldest expectation.
    always @(negedge clk) begin
        if (!rstn) begin
            comp_prev = 1'b0;
        end else begin
            if (completed && !comp_prev) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_completion: instr %h pc %h, expected no completion", instr_raw, pc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (instr_raw !== e.instr || pc !== e.pc || misaligned !== e.mis) begin
                        errors++;
                        $display("FAIL completion: instr %h pc %h mis %b expected instr %h pc %h mis %b",
                                 instr_raw, pc, misaligned, e.instr, e.pc, e.mis);
                    end
                end
            end
            comp_prev = completed;
        end
    end

    always @(negedge clk) begin
        if (rstn) assert (!(enabled && !flush && mem_req)) else $error("protocol: enabled while busy");
    end

    initial begin
        #200000;
        $display("FAIL sim_timeout: still running, expected finish");
        $fatal(1);
    end

    initial begin
        step();
        step();
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, RPC);
        chk("rst_pc", pc, RPC);
        chk("rst_instr", instr_raw, 32'd0);
        chk("rst_flags", {28'd0, completed, misaligned, fault, mem_req}, 32'd0);
        rstn = 1'b1;
        step();

        // 1: ack in the first request cycle
        expect_done(32'h0050_0093, 32'h100, 1'b0);
        enabled = 1'b1; pc_in = 32'h100; mem_rdata = 32'h0050_0093; mem_ack = 1'b1;
        step();
        enabled = 1'b0;
        chk("t1_req", {31'd0, mem_req}, 32'd1);
        chk("t1_addr", mem_addr, 32'h100);
        chk("t1_not_done", {31'd0, completed}, 32'd0);
        step();
        mem_ack = 1'b0;
        chk("t1_req_drop", {31'd0, mem_req}, 32'd0);
        chk("t1_done", {31'd0, completed}, 32'd1);
        step();

        // 2: ack delayed by five cycles
        expect_done(32'h1111_1111, 32'h204, 1'b0);
        enabled = 1'b1; pc_in = 32'h204; mem_rdata = 32'h1111_1111;
        step();
        enabled = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t2_req_held", {31'd0, mem_req}, 32'd1);
            chk("t2_addr_stable", mem_addr, 32'h204);
            chk("t2_wait", {31'd0, completed}, 32'd0);
            step();
        end
        mem_ack = 1'b1;
        chk("t2_req_6th", {31'd0, mem_req}, 32'd1);
        step();
        mem_ack = 1'b0;
        chk("t2_done", {31'd0, completed}, 32'd1);
        chk("t2_req_drop", {31'd0, mem_req}, 32'd0);
        step();

        // 3: flush mid-request, late ack is dropped
        enabled = 1'b1; pc_in = 32'h300;
        step();
        enabled = 1'b0;
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t3_req_kept", {31'd0, mem_req}, 32'd1);
        step();
        step();
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_ack = 1'b0;
        chk("t3_req_drop", {31'd0, mem_req}, 32'd0);
        chk("t3_no_done", {31'd0, completed}, 32'd0);
        chk("t3_instr_kept", instr_raw, 32'h1111_1111);
        step();
        chk("t3_no_done2", {31'd0, completed}, 32'd0);

        // 4: flush with a new start while busy
        enabled = 1'b1; pc_in = 32'h400;
        step();
        enabled = 1'b0;
        step();
        expect_done(32'hCAFE_F00D, 32'h200, 1'b0);
        flush = 1'b1; enabled = 1'b1; pc_in = 32'h200;
        step();
        flush = 1'b0; enabled = 1'b0;
        chk("t4_drain_req", {31'd0, mem_req}, 32'd1);
        chk("t4_drain_addr", mem_addr, 32'h400);
        step();
        mem_ack = 1'b1; mem_rdata = 32'hBAAD_BAAD;
        step();
        mem_ack = 1'b0; mem_rdata = 32'hCAFE_F00D;
        chk("t4_gap_no_done", {31'd0, completed}, 32'd0);
        step();
        chk("t4_reissue_req", {31'd0, mem_req}, 32'd1);
        chk("t4_reissue_addr", mem_addr, 32'h200);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("t4_done", {31'd0, completed}, 32'd1);
        chk("t4_instr", instr_raw, 32'hCAFE_F00D);
        step();

        // 5: watchdog with an 8-cycle limit
        enabled = 1'b1; pc_in = 32'h500;
        step();
        enabled = 1'b0;
        for (int i = 0; i < 7; i++) begin
            chk("t5_no_fault_yet", {30'd0, fault, mem_req}, 32'd1);
            step();
        end
        step();
        chk("t5_fault", {31'd0, fault}, 32'd1);
        chk("t5_req_drop", {31'd0, mem_req}, 32'd0);
        enabled = 1'b1; pc_in = 32'h600;
        step();
        enabled = 1'b0;
        chk("t5_ignored", {31'd0, mem_req}, 32'd0);
        step();
        chk("t5_ignored2", {30'd0, completed, mem_req}, 32'd0);
        chk("t5_sticky", {31'd0, fault}, 32'd1);

        // 6: async reset mid-request, then an unaligned start
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        chk("t6_fault_clr", {31'd0, fault}, 32'd0);
        enabled = 1'b1; pc_in = 32'h700;
        step();
        enabled = 1'b0;
        step();
        chk("t6_busy", {31'd0, mem_req}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("t6_async_req", {31'd0, mem_req}, 32'd0);
        chk("t6_async_addr", mem_addr, RPC);
        chk("t6_async_pc", pc, RPC);
        chk("t6_async_instr", instr_raw, 32'd0);
        step();
        rstn = 1'b1;
        step();
`ifdef FETCH_MISALIGN_CHECK_EN
        expect_done(32'd0, 32'h102, 1'b1);
        enabled = 1'b1; pc_in = 32'h102;
        step();
        enabled = 1'b0;
        chk("t6_mis_no_req", {31'd0, mem_req}, 32'd0);
        chk("t6_mis_flag", {31'd0, misaligned}, 32'd1);
        chk("t6_mis_done", {31'd0, completed}, 32'd1);
        step();
        enabled = 1'b1; pc_in = 32'h800;
        step();
        enabled = 1'b0;
        chk("t6_mis_clear", {31'd0, misaligned}, 32'd0);
        expect_done(32'h0000_0013, 32'h800, 1'b0);
        mem_rdata = 32'h0000_0013; mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
`else
        expect_done(32'h0000_0013, 32'h102, 1'b0);
        enabled = 1'b1; pc_in = 32'h102; mem_rdata = 32'h0000_0013;
        step();
        enabled = 1'b0;
        chk("t6_aligned_addr", mem_addr, 32'h100);
        chk("t6_req", {31'd0, mem_req}, 32'd1);
        chk("t6_no_mis", {31'd0, misaligned}, 32'd0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
`endif
        step();
        step();
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
